// File: rtl/ex_hazard_ctrl_if.sv
// Signal bundle between the EX-stage pipeline datapath and its hazard sequencer.
// The pipeline (master) presents the instructions, the MWB write port and the memory
// handshake; the sequencer (slave) returns stall, flush and bypass controls.
interface ex_hazard_ctrl_if;
    logic [31:0] IFD_EX_IR;
    logic [31:0] EX_IR;
    logic [4:0]  EX_dest_reg;
    logic        writeflag;
    logic [4:0]  dest_addr;
    logic        condn_flag;
    logic        mem_req;
    logic        mem_ready;
    logic        ex_stall;
    logic        if_stall;
    logic        flush;
    logic [1:0]  Bypass_Flag;
    logic        mem_err;
    logic [1:0]  state;

    modport master (
        output IFD_EX_IR, EX_IR, EX_dest_reg, writeflag, dest_addr, condn_flag, mem_ready,
        input  mem_req, ex_stall, if_stall, flush, Bypass_Flag, mem_err, state
    );

    modport slave (
        input  IFD_EX_IR, EX_IR, EX_dest_reg, writeflag, dest_addr, condn_flag, mem_ready,
        output mem_req, ex_stall, if_stall, flush, Bypass_Flag, mem_err, state
    );
endinterface

// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard sequencer: load-use bubbles, memory-wait stalls with timeout,
// branch flush window and registered operand bypass selects.
module ex_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 1,   // 1..7
    parameter int MEM_TIMEOUT  = 15   // 1..255
) (
    input  logic            clk,
    input  logic            rst,
    ex_hazard_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        RUN       = 2'b00,
        LOAD_WAIT = 2'b01,
        FLUSH     = 2'b10
    } state_e;

    localparam logic [4:0] OP_R      = 5'b01100;
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_IMM    = 5'b00100;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_BRANCH = 5'b11000;

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [7:0] TMO_LIMIT  = 8'(MEM_TIMEOUT);

    state_e      state_q, state_d;
    logic [2:0]  flush_cnt_q, flush_cnt_d;
    logic [7:0]  tmo_cnt_q, tmo_cnt_d;
    logic        mem_err_q, mem_err_d;
    logic [1:0]  byp_q, byp_d;
    logic        bubble_q, bubble_d;
    logic        load_use;
    logic        stall;

    logic [4:0]  ex_op, id_op, rd, rs1, rs2;
    logic        ex_is_load, ex_is_mem, ex_fwd_writer;
    logic        id_uses_rs1, id_uses_rs2, rs1_hit, rs2_hit;

    // The MWB port writes the register file on the same edge EX reads it, so it never
    // needs a bypass; instruction bits outside opcode/register fields are not decoded.
    logic unused_bits;
    assign unused_bits = ^{bus.writeflag, bus.dest_addr,
                           bus.IFD_EX_IR[31:25], bus.IFD_EX_IR[14:7], bus.IFD_EX_IR[1:0],
                           bus.EX_IR[31:7], bus.EX_IR[1:0]};

    assign ex_op = bus.EX_IR[6:2];
    assign id_op = bus.IFD_EX_IR[6:2];
    assign rd    = bus.EX_dest_reg;
    assign rs1   = bus.IFD_EX_IR[19:15];
    assign rs2   = bus.IFD_EX_IR[24:20];

    assign ex_is_load    = (ex_op == OP_LOAD);
    assign ex_is_mem     = ex_is_load || (ex_op == OP_STORE);
    // A load's data is not ready in EX, so it is covered by the bubble instead of a bypass.
    assign ex_fwd_writer = (ex_op == OP_R) || (ex_op == OP_IMM);
    assign id_uses_rs1   = id_op inside {OP_R, OP_LOAD, OP_IMM, OP_STORE, OP_BRANCH};
    assign id_uses_rs2   = id_op inside {OP_R, OP_STORE, OP_BRANCH};
    assign rs1_hit       = id_uses_rs1 && (rd != 5'd0) && (rs1 == rd);
    assign rs2_hit       = id_uses_rs2 && (rd != 5'd0) && (rs2 == rd);

    // Next-state, counters, stall decision and bypass-select update.
    always_comb begin
        // NOTE: every variable gets a default before the case, so no path leaves one
        // unassigned and no latch is inferred.
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        mem_err_d   = mem_err_q;
        load_use    = 1'b0;
        stall       = 1'b0;

        case (state_q)
            RUN: begin
                if (bus.condn_flag) begin
                    state_d     = FLUSH;
                    flush_cnt_d = FLUSH_LOAD;
                end else if (ex_is_mem && !bus.mem_ready) begin
                    state_d   = LOAD_WAIT;
                    tmo_cnt_d = 8'd0;
                end else if (ex_is_load && (rs1_hit || rs2_hit) && !bubble_q) begin
                    // bubble_q limits the load-use hold to a single cycle
                    load_use = 1'b1;
                    stall    = 1'b1;
                end
            end
            LOAD_WAIT: begin
                stall = 1'b1;
                if (bus.mem_ready) begin
                    state_d   = RUN;
                    tmo_cnt_d = 8'd0;
                end else if (tmo_cnt_q + 8'd1 == TMO_LIMIT) begin
                    mem_err_d = 1'b1;
                    state_d   = RUN;
                    tmo_cnt_d = 8'd0;
                end else if (tmo_cnt_q != 8'hFF) begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
            end
            FLUSH: begin
                if (flush_cnt_q == 3'd0) begin
                    state_d = RUN;
                end else begin
                    flush_cnt_d = flush_cnt_q - 3'd1;
                end
            end
            default: state_d = RUN;
        endcase

        // Wrong-path and post-bubble operands must come from the register file.
        byp_d = byp_q;
        if ((state_q == FLUSH) || (state_d == FLUSH) || load_use) begin
            byp_d = 2'b00;
        end else if (!stall) begin
            byp_d = {ex_fwd_writer && rs2_hit, ex_fwd_writer && rs1_hit};
        end
        bubble_d = load_use;
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge values.
        if (rst) begin
            state_q     <= RUN;
            flush_cnt_q <= 3'd0;
            tmo_cnt_q   <= 8'd0;
            mem_err_q   <= 1'b0;
            byp_q       <= 2'b00;
            bubble_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            mem_err_q   <= mem_err_d;
            byp_q       <= byp_d;
            bubble_q    <= bubble_d;
        end
    end

    assign bus.state       = state_q;
    assign bus.flush       = (state_q == FLUSH);
    assign bus.ex_stall    = stall;
    assign bus.if_stall    = stall;
    assign bus.mem_req     = !rst && (state_q != FLUSH) && ex_is_mem;
    assign bus.Bypass_Flag = byp_q;
    assign bus.mem_err     = mem_err_q;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Bench for ex_hazard_ctrl: directed scenarios followed by randomized traffic, all
// checked each cycle against a cycle-level behavioural model of the sequencer rules.
module tb_ex_hazard_ctrl;

    localparam int FC = 3;
    localparam int MT = 15;

    localparam int K_R = 0, K_LD = 1, K_IMM = 2, K_ST = 3, K_BR = 4, K_NONE = 5;
    localparam logic [31:0] NOP = 32'hFFFF_FFFF;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ex_hazard_ctrl_if bus();

    ex_hazard_ctrl #(.FLUSH_CYCLES(FC), .MEM_TIMEOUT(MT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Model state: mode 0 run, 1 waiting on memory, 2 flushing.
    int         m_mode       = 0;
    int         m_flush_left = 0;
    int         m_waited     = 0;
    logic       m_err        = 1'b0;
    logic [1:0] m_byp        = 2'b00;
    bit         m_bubble     = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int kind(input logic [31:0] ir);
        case (ir[6:2])
            5'b01100: return K_R;
            5'b00000: return K_LD;
            5'b00100: return K_IMM;
            5'b01000: return K_ST;
            5'b11000: return K_BR;
            default:  return K_NONE;
        endcase
    endfunction

    // Does the IFD instruction read the EX destination on operand 1 or 2?
    function automatic bit hit(input int which);
        int k;
        logic [4:0] rs;
        bit uses;
        k = kind(bus.IFD_EX_IR);
        if (which == 1) begin
            uses = (k != K_NONE);
            rs   = bus.IFD_EX_IR[19:15];
        end else begin
            uses = (k == K_R) || (k == K_ST) || (k == K_BR);
            rs   = bus.IFD_EX_IR[24:20];
        end
        return uses && (bus.EX_dest_reg != 5'd0) && (rs == bus.EX_dest_reg);
    endfunction

    function automatic bit ex_mem();
        int k;
        k = kind(bus.EX_IR);
        return (k == K_LD) || (k == K_ST);
    endfunction

    function automatic bit exp_load_use();
        return (m_mode == 0) && !bus.condn_flag && !(ex_mem() && !bus.mem_ready)
            && (kind(bus.EX_IR) == K_LD) && (hit(1) || hit(2)) && !m_bubble;
    endfunction

    // Compare every output against the model mid-cycle.
    task automatic settle();
        bit e_stall;
        #1;
        e_stall = (m_mode == 1) || exp_load_use();
        check("state",    bus.state,       m_mode);
        check("flush",    bus.flush,       m_mode == 2);
        check("ex_stall", bus.ex_stall,    e_stall);
        check("if_stall", bus.if_stall,    e_stall);
        check("mem_req",  bus.mem_req,     !rst && (m_mode != 2) && ex_mem());
        check("bypass",   bus.Bypass_Flag, m_byp);
        check("mem_err",  bus.mem_err,     m_err);
    endtask

    // Advance one clock and apply the sequencer rules to the model.
    task automatic tick();
        bit lu, st, fwd;
        int nw;
        lu  = exp_load_use();
        st  = (m_mode == 1) || lu;
        fwd = (kind(bus.EX_IR) == K_R) || (kind(bus.EX_IR) == K_IMM);
        @(posedge clk);
        if (rst) begin
            m_mode = 0; m_flush_left = 0; m_waited = 0;
            m_err = 1'b0; m_byp = 2'b00; m_bubble = 1'b0;
        end else begin
            nw = m_mode;
            case (m_mode)
                0: begin
                    if (bus.condn_flag) begin
                        nw = 2; m_flush_left = FC;
                    end else if (ex_mem() && !bus.mem_ready) begin
                        nw = 1; m_waited = 0;
                    end
                end
                1: begin
                    m_waited++;
                    if (bus.mem_ready) nw = 0;
                    else if (m_waited == MT) begin m_err = 1'b1; nw = 0; end
                end
                default: begin
                    m_flush_left--;
                    if (m_flush_left == 0) nw = 0;
                end
            endcase
            if (m_mode == 2 || nw == 2 || lu) m_byp = 2'b00;
            else if (!st) m_byp = {fwd && hit(2), fwd && hit(1)};
            m_mode   = nw;
            m_bubble = lu;
        end
        @(negedge clk);
    endtask

    function automatic logic [31:0] r_ir(input int rd, input int rs1, input int rs2);
        return {7'b0, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 5'b01100, 2'b11};
    endfunction

    function automatic logic [31:0] ld_ir(input int rd, input int rs1);
        return {12'd0, 5'(rs1), 3'b010, 5'(rd), 5'b00000, 2'b11};
    endfunction

    function automatic logic [31:0] rand_ir();
        logic [31:0] ir;
        logic [4:0]  ops [6];
        ops = '{5'b01100, 5'b00000, 5'b00100, 5'b01000, 5'b11000, 5'b10100};
        ir        = $urandom;
        ir[6:2]   = ops[$urandom_range(0, 5)];
        ir[11:7]  = 5'($urandom_range(0, 3));
        ir[19:15] = 5'($urandom_range(0, 3));
        ir[24:20] = 5'($urandom_range(0, 3));
        return ir;
    endfunction

    task automatic set_ir(input logic [31:0] ex, input logic [31:0] ifd);
        bus.EX_IR       = ex;
        bus.EX_dest_reg = ex[11:7];
        bus.IFD_EX_IR   = ifd;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        set_ir(NOP, NOP);
        bus.EX_dest_reg = 5'd0;
        bus.writeflag   = 1'b0;
        bus.dest_addr   = 5'd0;
        bus.condn_flag  = 1'b0;
        bus.mem_ready   = 1'b1;
        @(posedge clk);
        @(negedge clk);

        // Reset state
        settle();
        check("rst_state", bus.state, 2'b00);
        tick();
        rst = 1'b0;
        bus.EX_dest_reg = 5'd0;
        settle(); tick();

        // ADD x5,x2,x7 in EX, SUB x6,x5,x4 in IFD; MWB writes x4 (no bypass needed)
        set_ir(r_ir(5, 2, 7), r_ir(6, 5, 4));
        bus.writeflag = 1'b1; bus.dest_addr = 5'd4;
        settle(); tick();
        bus.writeflag = 1'b0;
        set_ir(r_ir(6, 5, 4), NOP);
        settle();
        check("fwd_byp", bus.Bypass_Flag, 2'b01);
        check("fwd_nostall", bus.ex_stall, 1'b0);
        tick();

        // LW x5 in EX, ADD x6,x4,x5 in IFD: one-cycle bubble
        set_ir(ld_ir(5, 1), r_ir(6, 4, 5));
        settle();
        check("lu_ex_stall", bus.ex_stall, 1'b1);
        check("lu_if_stall", bus.if_stall, 1'b1);
        tick();
        bus.EX_IR = NOP; bus.EX_dest_reg = 5'd0;
        settle();
        check("lu_release", bus.ex_stall, 1'b0);
        check("lu_byp1", bus.Bypass_Flag[1], 1'b0);
        tick();
        set_ir(r_ir(6, 4, 5), NOP);
        settle(); tick();

        // LW with mem_ready low three cycles
        set_ir(ld_ir(7, 2), NOP);
        bus.mem_ready = 1'b0;
        settle(); tick();
        for (int i = 0; i < 3; i++) begin
            if (i == 2) bus.mem_ready = 1'b1;
            settle();
            check("w3_state", bus.state, 2'b01);
            tick();
        end
        set_ir(NOP, NOP);
        settle();
        check("w3_run", bus.state, 2'b00);
        check("w3_noerr", bus.mem_err, 1'b0);
        tick();

        // Memory timeout: mem_err sets after MT waiting cycles and stays set
        set_ir(ld_ir(7, 2), NOP);
        bus.mem_ready = 1'b0;
        settle(); tick();
        for (int i = 0; i < MT; i++) begin
            settle();
            check("tmo_wait", bus.state, 2'b01);
            tick();
        end
        set_ir(NOP, NOP);
        settle();
        check("tmo_run", bus.state, 2'b00);
        check("tmo_err", bus.mem_err, 1'b1);
        tick();
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("tmo_sticky", bus.mem_err, 1'b1);
            tick();
        end

        // Taken branch with a load-use pattern present: flush wins, no stall
        set_ir(ld_ir(5, 1), r_ir(6, 5, 0));
        bus.condn_flag = 1'b1;
        settle();
        check("br_nostall", bus.ex_stall, 1'b0);
        tick();
        bus.condn_flag = 1'b0;
        set_ir(NOP, NOP);
        for (int i = 0; i < FC; i++) begin
            bus.condn_flag = (i == 1);
            settle();
            check("fl_flush", bus.flush, 1'b1);
            check("fl_stall", bus.if_stall, 1'b0);
            tick();
        end
        bus.condn_flag = 1'b0;
        settle();
        check("fl_done", bus.flush, 1'b0);
        tick();

        // Reset asserted on the second LOAD_WAIT cycle
        set_ir(ld_ir(5, 1), NOP);
        bus.mem_ready = 1'b0;
        settle(); tick();
        settle(); tick();
        rst = 1'b1;
        settle();
        check("rst_memreq", bus.mem_req, 1'b0);
        tick();
        rst = 1'b0;
        set_ir(NOP, NOP);
        settle();
        check("rst_run", bus.state, 2'b00);
        check("rst_err", bus.mem_err, 1'b0);
        check("rst_byp", bus.Bypass_Flag, 2'b00);
        check("rst_stall", bus.ex_stall, 1'b0);
        tick();

        // Randomized traffic: fast memory, then slow memory to reach timeouts
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            set_ir(rand_ir(), rand_ir());
            bus.condn_flag = ($urandom_range(0, 7) == 0);
            bus.mem_ready  = (i < 300) ? ($urandom_range(0, 3) != 0)
                                       : ($urandom_range(0, 11) == 0);
            bus.writeflag  = 1'($urandom_range(0, 1));
            bus.dest_addr  = 5'($urandom_range(0, 3));
            settle();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
